// File: rtl/chan_deframer.sv
// chan_deframer
// Receive-side deframer for the multi-channel DDC sample stream. Serialized
// samples (I0, Q0, I1, Q1, ... I(N-1), Q(N-1), repeating) are re-paired per
// channel. Each pair is tagged with its channel index and an end-of-frame
// flag, then queued in a first-word-fall-through FIFO that feeds an
// AXI-stream master.
//
// Ports:
//   aclk, rst         clock (rising edge) and synchronous active-high reset
//   s_data/s_valid    input sample stream; it has no ready and cannot be stalled
//   s_first           qualified by s_valid; marks the I sample of channel 0
//   m_axis_tdata      {Q, I}, with I in the low half
//   m_axis_tuser      channel index of the pair
//   m_axis_tlast      high on channel NUM_CHANS-1
//   m_axis_tvalid/m_axis_tready  AXI-stream handshake
//   ovf_count         words dropped on a full FIFO (saturating)
//   sync_err_count    resync events (saturating)
//   locked            high once a frame start has been seen since reset
//
// Handshake: a word transfers at a rising edge where m_axis_tvalid and
// m_axis_tready are both high. While tvalid is high and tready is low, the
// presented word is held unchanged and tvalid stays high.
module chan_deframer #(
    parameter int SAMP_WIDTH = 16,
    parameter int NUM_CHANS  = 13,
    parameter int CHAN_WIDTH = 4,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic [SAMP_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    input  logic                    s_first,
    output logic [2*SAMP_WIDTH-1:0] m_axis_tdata,
    output logic [CHAN_WIDTH-1:0]   m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [15:0]             ovf_count,
    output logic [15:0]             sync_err_count,
    output logic                    locked
);

    localparam int NUM_SLOTS = 2 * NUM_CHANS;
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int ADDR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WORD_W    = 1 + CHAN_WIDTH + 2 * SAMP_WIDTH;

    localparam logic [SLOT_W-1:0]     LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [SLOT_W-1:0]     SLOT_ONE  = SLOT_W'(1);
    localparam logic [CHAN_WIDTH-1:0] LAST_CHAN = CHAN_WIDTH'(NUM_CHANS - 1);
    localparam logic [ADDR_W:0]       PTR_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]       FULL_OCC  = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [SLOT_W-1:0]     slot;
    logic [SAMP_WIDTH-1:0] i_hold;
    logic                  locked_r;

    // Pointers carry one extra bit so that full and empty are distinguishable.
    logic [WORD_W-1:0]     mem [FIFO_DEPTH];
    logic [ADDR_W:0]       wr_ptr;
    logic [ADDR_W:0]       rd_ptr;
    logic [ADDR_W:0]       occ;

    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  resync;
    logic                  push_req;
    logic                  push;
    logic [CHAN_WIDTH-1:0] chan;
    logic [WORD_W-1:0]     wr_word;
    logic [WORD_W-1:0]     rd_word;

    always_comb begin
        occ      = wr_ptr - rd_ptr;
        empty    = (occ == '0);
        full     = (occ == FULL_OCC);
        pop      = !empty && m_axis_tready;
        // A frame start in any slot other than 0 restarts the frame.
        resync   = s_valid && s_first && locked_r && (slot != '0);
        chan     = CHAN_WIDTH'(slot >> 1);
        // Only an odd slot completes a pair. On a resync the sample becomes
        // a new I, so the partial pair is never pushed.
        push_req = s_valid && locked_r && !resync && slot[0];
        // A pop at the same edge frees the slot that the push needs.
        push     = push_req && (!full || pop);
        wr_word  = {(chan == LAST_CHAN), chan, s_data, i_hold};
        rd_word  = mem[rd_ptr[ADDR_W-1:0]];
    end

    // Outputs read zero while empty. Memory contents are never reset.
    assign m_axis_tvalid = !empty;
    assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = empty ? '0 : rd_word;
    assign locked = locked_r;

    always_ff @(posedge aclk) begin
        if (rst) begin
            slot           <= '0;
            i_hold         <= '0;
            locked_r       <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ovf_count      <= '0;
            sync_err_count <= '0;
        end else begin
            if (s_valid) begin
                if (!locked_r) begin
                    // Samples are discarded until the first frame start.
                    // The frame start itself is taken as slot 0.
                    if (s_first) begin
                        locked_r <= 1'b1;
                        i_hold   <= s_data;
                        slot     <= SLOT_ONE;
                    end
                end else if (resync) begin
                    i_hold <= s_data;
                    slot   <= SLOT_ONE;
                    if (sync_err_count != 16'hFFFF)
                        sync_err_count <= sync_err_count + 16'd1;
                end else begin
                    if (!slot[0])
                        i_hold <= s_data;
                    slot <= (slot == LAST_SLOT) ? '0 : slot + SLOT_ONE;
                end
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            // A dropped word still advances the slot, so channel tags stay aligned.
            if (push_req && !push && (ovf_count != 16'hFFFF))
                ovf_count <= ovf_count + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push)
            mem[wr_ptr[ADDR_W-1:0]] <= wr_word;
    end

endmodule

// File: tb/tb_chan_deframer.sv
module tb_chan_deframer;

  localparam int SW = 16;
  localparam int NC = 13;
  localparam int CW = 4;
  localparam int FD = 32;
  localparam int WW = 1 + CW + 2 * SW;

  logic            aclk = 1'b0;
  logic            rst;
  logic [SW-1:0]   s_data;
  logic            s_valid;
  logic            s_first;
  logic [2*SW-1:0] m_axis_tdata;
  logic [CW-1:0]   m_axis_tuser;
  logic            m_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [15:0]     ovf_count;
  logic [15:0]     sync_err_count;
  logic            locked;

  int total = 0;
  int bad   = 0;
  logic [WW-1:0] exp_q[$];

  chan_deframer #(
    .SAMP_WIDTH(SW),
    .NUM_CHANS (NC),
    .CHAN_WIDTH(CW),
    .FIFO_DEPTH(FD)
  ) dut (
    .aclk          (aclk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_first       (s_first),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .ovf_count     (ovf_count),
    .sync_err_count(sync_err_count),
    .locked        (locked)
  );

  // clock / watchdog
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [WW-1:0] mk_word(input int ch, input logic [15:0] base);
    logic [15:0] i_s;
    logic [15:0] q_s;
    i_s = 16'h0100 + base + 16'(ch);
    q_s = 16'h0200 + base + 16'(ch);
    return {(ch == NC - 1), CW'(ch), q_s, i_s};
  endfunction

  // driver: one sample per call, presented for exactly one rising edge
  task automatic send(input logic [15:0] d, input logic f);
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    @(posedge aclk);
    #1;
    s_valid = 1'b0;
    s_first = 1'b0;
    s_data  = '0;
  endtask

  task automatic send_pair(input int ch, input logic [15:0] base, input logic first,
                           input logic expect_it, input logic chk_lat);
    send(16'h0100 + base + 16'(ch), first);
    if (expect_it) exp_q.push_back(mk_word(ch, base));
    send(16'h0200 + base + 16'(ch), 1'b0);
    if (chk_lat) check("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
  endtask

  // monitor / scoreboard: compare on every handshake, check holds while stalled
  logic          stall;
  logic [WW-1:0] held;
  logic [WW-1:0] cur;
  logic [WW-1:0] e;

  initial stall = 1'b0;

  always @(negedge aclk) begin
    cur = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("hold_word", 64'(cur), 64'(held));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", cur, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_word", 64'(cur), 64'(e));
        end
      end
      stall = m_axis_tvalid && !m_axis_tready;
      held  = cur;
    end
  end

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_first = 1'b0;
    s_data = '0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    // reset state
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_tuser", 64'(m_axis_tuser), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_ovf", 64'(ovf_count), 64'd0);
    check("rst_sync", 64'(sync_err_count), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    rst = 1'b0;

    // pre-lock discard, then two frames
    for (int i = 0; i < 7; i++) send(16'h7000 + 16'(i), 1'b0);
    check("prelock_locked", 64'(locked), 64'd0);
    check("prelock_tvalid", 64'(m_axis_tvalid), 64'd0);
    send(16'h0100, 1'b1);
    check("lock_rise", 64'(locked), 64'd1);
    exp_q.push_back(mk_word(0, 16'h0000));
    send(16'h0200, 1'b0);
    check("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
    for (int ch = 1; ch < NC; ch++) send_pair(ch, 16'h0000, 1'b0, 1'b1, 1'b1);
    for (int ch = 0; ch < NC; ch++) send_pair(ch, 16'h0000, ch == 0, 1'b1, 1'b1);
    check("lock_sync", 64'(sync_err_count), 64'd0);
    check("lock_ovf", 64'(ovf_count), 64'd0);

    // resync: frame start arrives in slot 9 after ch 4's I sample
    for (int ch = 0; ch < 4; ch++) send_pair(ch, 16'h1000, ch == 0, 1'b1, 1'b1);
    send(16'h1104, 1'b0);
    check("resync_before", 64'(sync_err_count), 64'd0);
    send(16'h2100, 1'b1);
    check("resync_count", 64'(sync_err_count), 64'd1);
    exp_q.push_back(mk_word(0, 16'h2000));
    send(16'h2200, 1'b0);
    check("latency_tvalid", 64'(m_axis_tvalid), 64'd1);
    for (int ch = 1; ch < NC; ch++) send_pair(ch, 16'h2000, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge aclk);
    #1;

    // back-pressure: 39 pairs into a 32-deep FIFO, the last 7 are dropped
    m_axis_tready = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int ch = 0; ch < NC; ch++)
        send_pair(ch, 16'h3000 + 16'(f) * 16'h1000, ch == 0, (f * NC + ch) < FD, 1'b0);
    check("ovf_count", 64'(ovf_count), 64'd7);
    check("ovf_sync", 64'(sync_err_count), 64'd1);
    check("ovf_tuser_head", 64'(m_axis_tuser), 64'd0);

    // full FIFO with a pop on the same edge as the Q sample
    send(16'h6100, 1'b1);
    exp_q.push_back(mk_word(0, 16'h6000));
    m_axis_tready = 1'b1;
    send(16'h6200, 1'b0);
    check("fullpop_ovf", 64'(ovf_count), 64'd7);
    for (int i = 0; i < FD; i++) begin
      @(negedge aclk);
      check("drain_tvalid", 64'(m_axis_tvalid), 64'd1);
    end
    @(negedge aclk);
    check("drain_empty", 64'(m_axis_tvalid), 64'd0);
    check("drain_exp_left", 64'(exp_q.size()), 64'd0);

    // reset mid-frame with 5 words queued (slot is 2 here, so this start is a resync)
    @(posedge aclk);
    #1;
    send_pair(0, 16'h7000, 1'b1, 1'b1, 1'b1);
    check("resync2_count", 64'(sync_err_count), 64'd2);
    send_pair(1, 16'h7000, 1'b0, 1'b1, 1'b1);
    send(16'h7102, 1'b0);
    m_axis_tready = 1'b0;
    exp_q.push_back(mk_word(2, 16'h7000));
    send(16'h7202, 1'b0);
    for (int ch = 3; ch < 7; ch++) send_pair(ch, 16'h7000, 1'b0, 1'b1, 1'b0);
    send(16'h7107, 1'b0);
    check("pre_rst_tuser", 64'(m_axis_tuser), 64'd2);
    rst = 1'b1;
    send(16'hBEEF, 1'b1);
    rst = 1'b0;
    exp_q.delete();
    check("rst2_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst2_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst2_ovf", 64'(ovf_count), 64'd0);
    check("rst2_sync", 64'(sync_err_count), 64'd0);
    check("rst2_locked", 64'(locked), 64'd0);

    m_axis_tready = 1'b1;
    send(16'h5555, 1'b0);
    check("post_rst_unlocked", 64'(locked), 64'd0);
    for (int ch = 0; ch < NC; ch++) send_pair(ch, 16'h8000, ch == 0, 1'b1, 1'b1);
    check("post_rst_locked", 64'(locked), 64'd1);

    // drain with a bounded wait
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge aclk);
    repeat (2) @(posedge aclk);
    check("final_exp_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chan_deframer.md
# chan_deframer

Receive-side counterpart to the multi-channel DDC output stream. Takes the serialized 16-bit post-FIR sample stream (I0, Q0, I1, Q1, … I(N-1), Q(N-1), repeating) plus a frame-start marker. Re-pairs I/Q per channel, tags each pair with its channel index and end-of-frame. Presents the pairs on a back-pressurable AXI-stream master through a small FIFO, with saturating overflow and resync counters for the PS.

## Interface
Parameters:
- SAMP_WIDTH, 16, width of one I or Q sample
- NUM_CHANS, 13, channels per frame (2·NUM_CHANS samples per frame)
- CHAN_WIDTH, 4, width of channel index; must satisfy 2^CHAN_WIDTH ≥ NUM_CHANS
- FIFO_DEPTH, 32, output FIFO depth in words (power of two)

Ports:
- aclk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_data  in  SAMP_WIDTH  input sample, two's complement
- s_valid  in  1  sample valid; no ready, input cannot be stalled
- s_first  in  1  qualified by s_valid; marks I sample of channel 0
- m_axis_tdata  out  2·SAMP_WIDTH  {Q, I}, I in low half
- m_axis_tuser  out  CHAN_WIDTH  channel index of the pair
- m_axis_tlast  out  1  high on channel NUM_CHANS-1
- m_axis_tvalid  out  1  AXI-stream valid
- m_axis_tready  in  1  AXI-stream ready
- ovf_count  out  16  words dropped on full FIFO, saturating
- sync_err_count  out  16  resync events, saturating
- locked  out  1  high once a frame start has been seen since reset

## Operation
- State: slot counter 0..2·NUM_CHANS-1, held I register, locked flag.
- While unlocked, samples are discarded. The first s_valid&&s_first sets locked and is taken as slot 0.
- While locked, each s_valid sample advances the slot. Slot 2·NUM_CHANS-1 wraps to 0.
- Even slot: latch s_data into the I register.
- Odd slot: form word {s_data, I}, chan = slot>>1, last = (chan == NUM_CHANS-1). Push to the FIFO.
- Resync: s_valid&&s_first while locked and slot ≠ 0:
  - sample is taken as slot 0
  - held I is discarded; nothing is pushed for the partial pair
  - sync_err_count increments
  - words already pushed for the partial frame stay in the FIFO (tuser lets downstream detect the gap)
- s_first on an odd slot follows the same resync rule.
- s_first when slot == 0 is normal and is not counted.
- FIFO push when full:
  - the word is dropped and ovf_count increments
  - the slot still advances, so channel tagging stays correct
- Full with a simultaneous pop counts as not full: the push succeeds and nothing is dropped.
- Counters saturate at 16'hFFFF and clear only on rst.
- Output follows AXI-stream rules:
  - tdata, tuser and tlast are stable while tvalid && !tready
  - tvalid never drops without a handshake
- Reset (rst high at an edge) clears: slot, I register, locked, FIFO pointers, both counters. Any frame in progress is abandoned.

## Timing
- Reset values:
  - m_axis_tvalid = 0
  - m_axis_tdata = 0
  - m_axis_tuser = 0
  - m_axis_tlast = 0
  - ovf_count = 0
  - sync_err_count = 0
  - locked = 0
- Latency: Q sample sampled at edge k, FIFO empty → m_axis_tvalid high in the cycle after edge k (first-word fall-through, 1 cycle).
- Throughput: one word per cycle out; at most one word per two input samples in.
- A pop happens at an edge where tvalid && tready. The next word, if present, is valid in the following cycle with no bubble.
- Full flag and drop decision use FIFO occupancy before the edge, corrected by a same-edge pop.
- Counter updates are visible the cycle after the causing edge.
- locked rises the cycle after the first accepted s_first.
- Inputs arriving in the same cycle rst is high are ignored.

## Test plan
- Lock and pairing: feed 2 frames, NUM_CHANS=13, I=0x0100+ch, Q=0x0200+ch, s_first on the first sample, tready=1.
  - Expect 26 words {0x0200+ch, 0x0100+ch}, tuser 0..12 twice.
  - tlast only on ch 12.
  - Each word's tvalid follows its Q sample by 1 cycle.
- Pre-lock discard: 7 samples without s_first, then a frame → output begins with ch 0, locked rises 1 cycle after s_first, sync_err_count = 0.
- Resync: s_first injected at slot 9 (ch 4 I).
  - Expect ch 0..3 words, then ch 0 of the new frame.
  - No ch 4 word; sync_err_count = 1.
- Back-pressure/overflow: tready=0, FIFO_DEPTH=32, stream 3 frames (39 pairs).
  - Expect 32 words held with tdata stable; ovf_count = 7.
  - Release tready → 32 words drain in 32 consecutive cycles, channel tags continuous modulo drops.
- Full with simultaneous pop: FIFO full, tready=1 on the cycle a Q arrives → word accepted, ovf_count unchanged.
- Reset mid-frame: rst asserted at slot 15 with 5 words queued.
  - Expect tvalid=0, counters 0, locked=0 next cycle.
  - Output after the next s_first starts at ch 0.
